// File: rtl/text_mode_pkg.sv
// Shared constants and side-band types for the text-mode pixel path.
//   CELL_W/CELL_H   character cell size in pixels
//   CHR_AW          chr_rom address width ({code, glyph_row})
//   CHR_CODE_W      character code width inside a text RAM word
//   LATENCY         input sample to pix/de/hs/vs output, in clock edges
//   ATTR_BIT        inverse-video bit inside a text RAM word
package text_mode_pkg;
    localparam int CELL_W      = 8;
    localparam int CELL_H      = 8;
    localparam int CHR_AW      = 10;
    localparam int CHR_CODE_W  = 7;
    localparam int LATENCY     = 5;
    localparam int ATTR_BIT    = 7;
    localparam int PIX_IDX_W   = $clog2(CELL_W);
    localparam int GLYPH_ROW_W = $clog2(CELL_H);

    // Per-pixel information that must line up with the chr_rom data.
    typedef struct packed {
        logic                 de;
        logic                 valid;
        logic                 hit;
        logic [PIX_IDX_W-1:0] x_pix;
    } side_t;
endpackage

// File: rtl/sync_delay.sv
// Fixed-length shift register, cleared to a per-bit value on reset.
//   clk, reset   pixel clock, synchronous active-high reset
//   d            W-bit input
//   q            d delayed by N clock edges
module sync_delay #(
    parameter int           W       = 1,
    parameter int           N       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] stage [N];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N; i++) stage[i] <= RST_VAL;
        end else begin
            stage[0] <= d;
            for (int i = 1; i < N; i++) stage[i] <= stage[i-1];
        end
    end

    assign q = stage[N-1];
endmodule

// File: rtl/text_pixel_gen.sv
// Text-mode pixel generator: coordinates -> text RAM -> chr_rom -> serial pixel.
//   clk, reset              pixel clock, synchronous active-high reset
//   x_in, y_in              pixel coordinates from the timing block
//   de_in, hs_in, vs_in     active video and syncs (syncs active at SYNC_POL)
//   cursor_en/col/row       blinking block cursor control
//   tram_ad, tram_dout      text RAM port (1-cycle synchronous read)
//   chr_ad, chr_dout        chr_rom port (1-cycle synchronous read)
//   pix_out                 pixel, 1 = foreground
//   de_out, hs_out, vs_out  inputs delayed by LATENCY edges
module text_pixel_gen
    import text_mode_pkg::*;
#(
    parameter int   COLS         = 80,
    parameter int   ROWS         = 60,
    parameter int   TRAM_AW      = 13,
    parameter int   BLINK_FRAMES = 16,
    parameter logic SYNC_POL     = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [9:0]         x_in,
    input  logic [9:0]         y_in,
    input  logic               de_in,
    input  logic               hs_in,
    input  logic               vs_in,
    input  logic               cursor_en,
    input  logic [6:0]         cursor_col,
    input  logic [5:0]         cursor_row,
    output logic [TRAM_AW-1:0] tram_ad,
    input  logic [7:0]         tram_dout,
    output logic [CHR_AW-1:0]  chr_ad,
    input  logic [7:0]         chr_dout,
    output logic               pix_out,
    output logic               de_out,
    output logic               hs_out,
    output logic               vs_out
);
    localparam int BLINK_W = $clog2(BLINK_FRAMES + 1);

    logic [6:0]             cell_col;
    logic [6:0]             cell_row;
    logic                   cell_valid;
    logic                   cursor_hit;
    logic [TRAM_AW-1:0]     lin_ad;
    logic [GLYPH_ROW_W-1:0] glyph_row_d;
    logic                   attr_d1;
    logic                   attr_d2;
    side_t                  side_in;
    side_t                  side_d;
    logic                   glyph_bit;
    logic                   vs_active;
    logic                   vs_active_prev;
    logic [BLINK_W-1:0]     blink_cnt;
    logic                   blink_on;

    assign cell_col   = x_in[9:3];
    assign cell_row   = y_in[9:3];
    assign cell_valid = ({25'd0, cell_col} < 32'(COLS)) && ({25'd0, cell_row} < 32'(ROWS));
    assign cursor_hit = cursor_en && (cell_col == cursor_col) && (cell_row == {1'b0, cursor_row});

    // Arithmetic at TRAM_AW width gives the modulo-2**TRAM_AW address directly.
    assign lin_ad = TRAM_AW'(cell_row) * TRAM_AW'(COLS) + TRAM_AW'(cell_col);

    // E0: text RAM address
    always_ff @(posedge clk) begin
        if (reset) tram_ad <= '0;
        else       tram_ad <= cell_valid ? lin_ad : '0;
    end

    // Glyph row must be ready when the RAM data arrives (E2).
    sync_delay #(.W(GLYPH_ROW_W), .N(2), .RST_VAL('0)) u_row_dly (
        .clk(clk), .reset(reset), .d(y_in[GLYPH_ROW_W-1:0]), .q(glyph_row_d)
    );

    // E2: chr_rom address and attribute capture; E3: attribute follows the ROM read.
    always_ff @(posedge clk) begin
        if (reset) begin
            chr_ad  <= '0;
            attr_d1 <= 1'b0;
            attr_d2 <= 1'b0;
        end else begin
            chr_ad  <= {tram_dout[CHR_CODE_W-1:0], glyph_row_d};
            attr_d1 <= tram_dout[ATTR_BIT];
            attr_d2 <= attr_d1;
        end
    end

    // Side-band consumed at E4 together with chr_dout, so one stage short of LATENCY.
    assign side_in = '{de: de_in, valid: cell_valid, hit: cursor_hit, x_pix: x_in[PIX_IDX_W-1:0]};

    sync_delay #(.W($bits(side_t)), .N(LATENCY - 1), .RST_VAL('0)) u_side_dly (
        .clk(clk), .reset(reset), .d(side_in), .q(side_d)
    );

    sync_delay #(.W(3), .N(LATENCY), .RST_VAL({1'b0, ~SYNC_POL, ~SYNC_POL})) u_sync_dly (
        .clk(clk), .reset(reset), .d({de_in, hs_in, vs_in}), .q({de_out, hs_out, vs_out})
    );

    // Bit 7 of the glyph row is the leftmost pixel.
    assign glyph_bit = chr_dout[3'd7 - side_d.x_pix];

    // E4: output pixel
    always_ff @(posedge clk) begin
        if (reset) pix_out <= 1'b0;
        else       pix_out <= side_d.de & side_d.valid & (glyph_bit ^ attr_d2 ^ (side_d.hit & blink_on));
    end

    // Blink: count frame starts (vs inactive->active); toggle on wrap.
    assign vs_active = (vs_in == SYNC_POL);

    always_ff @(posedge clk) begin
        if (reset) begin
            vs_active_prev <= 1'b1;   // no frame start counted for a vs held active through reset
            blink_cnt      <= '0;
            blink_on       <= 1'b1;
        end else begin
            vs_active_prev <= vs_active;
            if (vs_active && !vs_active_prev) begin
                if (blink_cnt == BLINK_W'(BLINK_FRAMES - 1)) begin
                    blink_cnt <= '0;
                    blink_on  <= ~blink_on;
                end else begin
                    blink_cnt <= blink_cnt + BLINK_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_text_pixel_gen.sv
module tb_text_pixel_gen;
    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  x_in, y_in;
    logic        de_in, hs_in, vs_in;
    logic        cursor_en;
    logic [6:0]  cursor_col;
    logic [5:0]  cursor_row;
    logic [12:0] tram_ad;
    logic [7:0]  tram_dout;
    logic [9:0]  chr_ad;
    logic [7:0]  chr_dout;
    logic        pix_out, de_out, hs_out, vs_out;

    logic [7:0] ram [0:8191];
    logic [7:0] rom [0:1023];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    text_pixel_gen #(
        .COLS(80), .ROWS(60), .TRAM_AW(13), .BLINK_FRAMES(2), .SYNC_POL(1'b0)
    ) dut (
        .clk(clk), .reset(reset),
        .x_in(x_in), .y_in(y_in), .de_in(de_in), .hs_in(hs_in), .vs_in(vs_in),
        .cursor_en(cursor_en), .cursor_col(cursor_col), .cursor_row(cursor_row),
        .tram_ad(tram_ad), .tram_dout(tram_dout),
        .chr_ad(chr_ad), .chr_dout(chr_dout),
        .pix_out(pix_out), .de_out(de_out), .hs_out(hs_out), .vs_out(vs_out)
    );

    // 1-cycle synchronous memories
    always @(posedge clk) begin
        tram_dout <= ram[tram_ad];
        chr_dout  <= rom[chr_ad];
    end

    task automatic drive(input int x, input int y, input logic de, input logic hs, input logic vs);
        x_in  = 10'(x);
        y_in  = 10'(y);
        de_in = de;
        hs_in = hs;
        vs_in = vs;
    endtask

    task automatic idle();
        drive(0, 0, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        idle();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic vs_pulse();
        @(negedge clk);
        drive(0, 0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        idle();
    endtask

    // Reference pixel: cursor at (5,7) enabled, blink_on assumed 1.
    function automatic logic model_pix(input int x, input int y, input logic de);
        int         col, row;
        logic [7:0] code, bits;
        col = x / 8;
        row = y / 8;
        if (!de || col >= 80 || row >= 60) return 1'b0;
        code = ram[row * 80 + col];
        bits = rom[int'(code[6:0]) * 8 + (y % 8)];
        return bits[7 - (x % 8)] ^ code[7] ^ ((col == 5) && (row == 7));
    endfunction

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (pix_out !== 1'b0) begin failures++; $display("FAIL reset_pix got=%b want=0", pix_out); end
        checks++; if (de_out !== 1'b0) begin failures++; $display("FAIL reset_de got=%b want=0", de_out); end
        checks++; if (hs_out !== 1'b1) begin failures++; $display("FAIL reset_hs got=%b want=1", hs_out); end
        checks++; if (vs_out !== 1'b1) begin failures++; $display("FAIL reset_vs got=%b want=1", vs_out); end
        checks++; if (tram_ad !== 13'd0) begin failures++; $display("FAIL reset_tram_ad got=%0d want=0", tram_ad); end
        checks++; if (chr_ad !== 10'd0) begin failures++; $display("FAIL reset_chr_ad got=%0d want=0", chr_ad); end
        reset = 1'b0;
    endtask

    task automatic test_glyph();
        logic [7:0] exp_bits;
        int j;
        exp_bits = 8'h30;
        ram[0] = 8'h41;
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            if (i >= 5) begin
                j = i - 5;
                checks++;
                if (pix_out !== exp_bits[7-j]) begin
                    failures++; $display("FAIL glyph_A_row0 px=%0d got=%b want=%b", j, pix_out, exp_bits[7-j]);
                end
                checks++;
                if (de_out !== 1'b1) begin failures++; $display("FAIL glyph_de px=%0d got=%b want=1", j, de_out); end
            end
            if (i < 8) drive(i, 0, 1'b1, 1'b1, 1'b1);
            else idle();
        end
    endtask

    task automatic test_inverse();
        logic [7:0] exp_bits;
        int j;
        exp_bits = 8'h87;
        ram[81] = 8'hC1;
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            if (i == 1) begin
                checks++;
                if (tram_ad !== 13'd81) begin failures++; $display("FAIL inv_tram_ad got=%0d want=81", tram_ad); end
            end
            if (i == 3) begin
                checks++;
                if (chr_ad !== 10'h209) begin failures++; $display("FAIL inv_chr_ad got=%h want=209", chr_ad); end
            end
            if (i >= 5) begin
                j = i - 5;
                checks++;
                if (pix_out !== exp_bits[7-j]) begin
                    failures++; $display("FAIL inverse_A_row1 px=%0d got=%b want=%b", j, pix_out, exp_bits[7-j]);
                end
            end
            if (i < 8) drive(8 + i, 9, 1'b1, 1'b1, 1'b1);
            else idle();
        end
    endtask

    task automatic test_boundary();
        int   vx [8]  = '{640, 641, 632, 700, 0, 8, 1023, 640};
        int   vy [8]  = '{0, 0, 0, 0, 480, 479, 1023, 8};
        logic vde [8] = '{1, 1, 1, 0, 1, 1, 1, 0};
        logic vhs [8] = '{1, 0, 0, 1, 1, 1, 0, 1};
        logic vvs [8] = '{1, 1, 1, 0, 0, 1, 0, 1};
        int   vad [8] = '{0, 0, 79, 0, 0, 4721, 0, 0};
        logic vpx [8] = '{0, 0, 1, 0, 0, 1, 0, 0};
        int j;
        ram[79]   = 8'hA0;
        ram[4721] = 8'h80;
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            if (i >= 1 && i <= 8) begin
                checks++;
                if (tram_ad !== 13'(vad[i-1])) begin
                    failures++; $display("FAIL bound_tram_ad vec=%0d got=%0d want=%0d", i - 1, tram_ad, vad[i-1]);
                end
            end
            if (i >= 5) begin
                j = i - 5;
                checks++;
                if (pix_out !== vpx[j]) begin failures++; $display("FAIL bound_pix vec=%0d got=%b want=%b", j, pix_out, vpx[j]); end
                checks++;
                if (de_out !== vde[j]) begin failures++; $display("FAIL bound_de vec=%0d got=%b want=%b", j, de_out, vde[j]); end
                checks++;
                if (hs_out !== vhs[j]) begin failures++; $display("FAIL bound_hs vec=%0d got=%b want=%b", j, hs_out, vhs[j]); end
                checks++;
                if (vs_out !== vvs[j]) begin failures++; $display("FAIL bound_vs vec=%0d got=%b want=%b", j, vs_out, vvs[j]); end
            end
            if (i < 8) drive(vx[i], vy[i], vde[i], vhs[i], vvs[i]);
            else idle();
        end
    endtask

    task automatic stream_cursor(input int frame, input logic solid, input string tag);
        logic want;
        int   j;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (i >= 5) begin
                j = i - 5;
                want = (j < 8) ? solid : 1'b0;
                checks++;
                if (pix_out !== want) begin
                    failures++; $display("FAIL %s frame=%0d px=%0d got=%b want=%b", tag, frame, j, pix_out, want);
                end
            end
            if (i < 9) drive(16 + i, 24 + frame, 1'b1, 1'b1, 1'b1);
            else idle();
        end
    endtask

    task automatic test_cursor_blink();
        ram[242] = 8'h20;
        ram[243] = 8'h20;
        cursor_col = 7'd2;
        cursor_row = 6'd3;
        cursor_en  = 1'b1;
        do_reset();
        for (int f = 0; f < 5; f++) begin
            stream_cursor(f, (f < 2) || (f == 4), "cursor_blink");
            if (f < 4) vs_pulse();
        end
    endtask

    task automatic test_mid_reset();
        logic [7:0] exp_bits;
        int j;
        exp_bits = 8'h87;
        vs_pulse();
        vs_pulse();
        stream_cursor(0, 1'b0, "blink_off_pre_reset");
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            drive(8 + k, 9, 1'b1, 1'b0, 1'b0);
        end
        @(negedge clk);
        reset = 1'b1;
        drive(13, 9, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        checks++; if (pix_out !== 1'b0) begin failures++; $display("FAIL midrst_pix got=%b want=0", pix_out); end
        checks++; if (de_out !== 1'b0) begin failures++; $display("FAIL midrst_de got=%b want=0", de_out); end
        checks++; if (hs_out !== 1'b1) begin failures++; $display("FAIL midrst_hs got=%b want=1", hs_out); end
        checks++; if (vs_out !== 1'b1) begin failures++; $display("FAIL midrst_vs got=%b want=1", vs_out); end
        checks++; if (tram_ad !== 13'd0) begin failures++; $display("FAIL midrst_tram_ad got=%0d want=0", tram_ad); end
        checks++; if (chr_ad !== 10'd0) begin failures++; $display("FAIL midrst_chr_ad got=%0d want=0", chr_ad); end
        reset = 1'b0;
        drive(8, 9, 1'b1, 1'b1, 1'b1);
        for (int s = 1; s < 13; s++) begin
            @(negedge clk);
            if (s < 5) begin
                checks++;
                if (pix_out !== 1'b0 || de_out !== 1'b0) begin
                    failures++; $display("FAIL midrst_stale s=%0d got pix=%b de=%b want pix=0 de=0", s, pix_out, de_out);
                end
            end else begin
                j = s - 5;
                checks++;
                if (pix_out !== exp_bits[7-j] || de_out !== 1'b1) begin
                    failures++;
                    $display("FAIL midrst_resume px=%0d got pix=%b de=%b want pix=%b de=1", j, pix_out, de_out, exp_bits[7-j]);
                end
            end
            if (s < 8) drive(8 + s, 9, 1'b1, 1'b1, 1'b1);
            else idle();
        end
        stream_cursor(0, 1'b1, "blink_on_after_reset");
    endtask

    task automatic test_full_frame();
        logic exp_q [$];
        logic e, de, hs;
        int   mism, first_bad, total, l, x, y;
        mism      = 0;
        first_bad = -1;
        total     = 60 * 656;
        for (int i = 0; i < 4800; i++) ram[i] = 8'(i);
        cursor_col = 7'd5;
        cursor_row = 6'd7;
        cursor_en  = 1'b1;
        do_reset();
        for (int n = 0; n < total + 5; n++) begin
            @(negedge clk);
            if (n >= 5) begin
                e = exp_q.pop_front();
                if (pix_out !== e) begin
                    mism++;
                    if (first_bad < 0) first_bad = n - 5;
                end
            end
            if (n < total) begin
                l  = n / 656;
                x  = n % 656;
                y  = l * 8 + (l % 8);
                de = (x < 640);
                hs = !(x >= 648 && x < 652);
                drive(x, y, de, hs, 1'b1);
                exp_q.push_back(model_pix(x, y, de));
            end else begin
                idle();
            end
        end
        checks++;
        if (mism != 0) begin
            failures++; $display("FAIL full_frame mismatches=%0d want=0 first_sample=%0d", mism, first_bad);
        end
    endtask

    initial begin
        reset      = 1'b1;
        cursor_en  = 1'b0;
        cursor_col = 7'd0;
        cursor_row = 6'd0;
        idle();
        for (int i = 0; i < 8192; i++) ram[i] = 8'h20;
        for (int a = 0; a < 1024; a++) rom[a] = 8'((a * 29 + 11) ^ (a >> 2));
        for (int r = 0; r < 8; r++) begin
            rom[r]            = 8'h00;
            rom[8'h20 * 8 + r] = 8'h00;
        end
        rom[8'h41*8+0] = 8'h30; rom[8'h41*8+1] = 8'h78;
        rom[8'h41*8+2] = 8'hCC; rom[8'h41*8+3] = 8'hCC;
        rom[8'h41*8+4] = 8'hFC; rom[8'h41*8+5] = 8'hCC;
        rom[8'h41*8+6] = 8'hCC; rom[8'h41*8+7] = 8'h00;

        test_reset();
        test_glyph();
        test_inverse();
        test_boundary();
        test_cursor_blink();
        test_mid_reset();
        test_full_frame();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
